// File: rtl/sum_loop_ctrl_pkg.sv
// Shared types for the sum/counter loop controller: state encoding, datapath
// control bundle and per-state control decode.
package sum_loop_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_CHECK = 3'd2,
        S_ADD   = 3'd3,
        S_INC   = 3'd4,
        S_OUT   = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    // Loop runs while i <= LOOP_LIMIT; the datapath performs the compare.
    localparam logic [7:0] LOOP_LIMIT = 8'd10;

    typedef struct packed {
        logic sum_src;
        logic i_src;
        logic sum_load;
        logic i_load;
        logic out_load;
        logic adder_src;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{
        sum_src: 1'b0, i_src: 1'b0, sum_load: 1'b0,
        i_load: 1'b0, out_load: 1'b0, adder_src: 1'b0
    };

    function automatic ctrl_t ctrl_for_state(input state_t s);
        ctrl_t c;
        c = CTRL_NONE;
        case (s)
            S_INIT: begin
                c.sum_load = 1'b1;
                c.i_load   = 1'b1;
            end
            S_ADD: begin
                c.sum_src  = 1'b1;
                c.sum_load = 1'b1;
            end
            S_INC: begin
                c.i_src     = 1'b1;
                c.adder_src = 1'b1;
                c.i_load    = 1'b1;
            end
            S_OUT:   c.out_load = 1'b1;
            default: c = CTRL_NONE;
        endcase
        return c;
    endfunction

    function automatic logic state_is_busy(input state_t s);
        logic b;
        case (s)
            S_INIT, S_CHECK, S_ADD, S_INC, S_OUT: b = 1'b1;
            default:                              b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sum_loop_ctrl_wdog.sv
// Loop-pass counter with clear/increment and a compare against the watchdog
// limit; the count is also exported as the controller's iter_count.
module sum_loop_ctrl_wdog #(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              incr_i,
    output logic [ITER_W-1:0] iter_count_o,
    output logic              limit_hit_o
);

    localparam logic [ITER_W-1:0] LIMIT = ITER_W'(MAX_ITER);
    localparam logic [ITER_W-1:0] ONE   = ITER_W'(1);

    logic [ITER_W-1:0] count_q;
    logic [ITER_W-1:0] count_d;

    // Next count: clear wins over increment; otherwise hold.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (incr_i) begin
            count_d = count_q + ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Pass counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign iter_count_o = count_q;
    assign limit_hit_o  = (count_q == LIMIT);

endmodule

// File: rtl/sum_loop_ctrl.sv
// Moore control FSM for the 8-bit sum loop datapath with start/busy/done,
// auto-restart and an iteration watchdog. Optional: SUM_LOOP_CTRL_STEP_EN adds a step qualifier.
module sum_loop_ctrl #(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              auto_restart,
    input  logic              iLe10,
`ifdef SUM_LOOP_CTRL_STEP_EN
    input  logic              step,
`endif
    output logic              sumSrcMuxSel,
    output logic              iSrcMuxSel,
    output logic              sumLoad,
    output logic              iLoad,
    output logic              outLoad,
    output logic              adderSrcMuxSel,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ITER_W-1:0] iter_count
);

    import sum_loop_ctrl_pkg::*;

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_s;
    logic   busy_q;
    logic   done_q;
    logic   err_q;
    logic   adv_s;
    logic   clear_s;
    logic   incr_s;
    logic   limit_hit_s;

`ifdef SUM_LOOP_CTRL_STEP_EN
    assign adv_s  = step;
    assign ctrl_s = step ? ctrl_q : CTRL_NONE;
`else
    assign adv_s  = 1'b1;
    assign ctrl_s = ctrl_q;
`endif

    sum_loop_ctrl_wdog #(
        .ITER_W   (ITER_W),
        .MAX_ITER (MAX_ITER)
    ) u_wdog (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (clear_s),
        .incr_i       (incr_s),
        .iter_count_o (iter_count),
        .limit_hit_o  (limit_hit_s)
    );

    // Next-state and watchdog strobes; run states only advance when adv_s is set.
    always_comb begin
        state_d = state_q;
        clear_s = 1'b0;
        incr_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_INIT;
                else       state_d = S_IDLE;
            end
            S_INIT: begin
                if (adv_s) begin
                    state_d = S_CHECK;
                    clear_s = 1'b1;
                end else begin
                    state_d = S_INIT;
                end
            end
            S_CHECK: begin
                if (!adv_s)           state_d = S_CHECK;
                else if (!iLe10)      state_d = S_OUT;
                else if (limit_hit_s) state_d = S_ERR;
                else                  state_d = S_ADD;
            end
            S_ADD: begin
                if (adv_s) begin
                    state_d = S_INC;
                    incr_s  = 1'b1;
                end else begin
                    state_d = S_ADD;
                end
            end
            S_INC: begin
                if (adv_s) state_d = S_CHECK;
                else       state_d = S_INC;
            end
            S_OUT: begin
                if (adv_s) state_d = S_DONE;
                else       state_d = S_OUT;
            end
            S_DONE: begin
                if (!adv_s)                       state_d = S_DONE;
                else if (start || auto_restart)   state_d = S_INIT;
                else                              state_d = S_IDLE;
            end
            S_ERR: begin
                if (start) state_d = S_INIT;
                else       state_d = S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register plus outputs decoded from the next state, so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ctrl_q  <= CTRL_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_for_state(state_d);
            busy_q  <= state_is_busy(state_d);
            done_q  <= (state_d == S_DONE);
            err_q   <= (state_d == S_ERR);
        end
    end

    assign sumSrcMuxSel   = ctrl_s.sum_src;
    assign iSrcMuxSel     = ctrl_s.i_src;
    assign sumLoad        = ctrl_s.sum_load;
    assign iLoad          = ctrl_s.i_load;
    assign outLoad        = ctrl_s.out_load;
    assign adderSrcMuxSel = ctrl_s.adder_src;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule
